// File: rtl/score_board.sv
// score_board: pong score keeper with a PLAY/OVER state machine, UART-key restart and seven-segment score rendering.
// Optional feature: define SCORE_BLINK_EN to blink the winner's digit (16 frames on, 16 off) while the game is over.
module score_board #(
    parameter int WIN_SCORE   = 5,
    parameter int RESTART_KEY = 114,
    parameter int P1_X        = 280,
    parameter int P2_X        = 336,
    parameter int DIGIT_Y     = 16
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_p1_scored,
    input  logic       i_p2_scored,
    input  logic       i_DataValid,
    input  logic [7:0] i_key_byte,
    input  logic [9:0] i_display_x_pos,
    input  logic [9:0] i_display_y_pos,
    output logic [2:0] o_red,
    output logic [2:0] o_green,
    output logic [2:0] o_blue,
    output logic [3:0] o_p1_score,
    output logic [3:0] o_p2_score,
    output logic       o_game_over,
    output logic       o_winner
);

    localparam logic [3:0] LP_WIN   = 4'(WIN_SCORE);
    localparam logic [7:0] LP_KEY   = 8'(RESTART_KEY);
    localparam logic [9:0] LP_P1_X  = 10'(P1_X);
    localparam logic [9:0] LP_P2_X  = 10'(P2_X);
    localparam logic [9:0] LP_Y     = 10'(DIGIT_Y);
    localparam logic [9:0] LP_W     = 10'd24;
    localparam logic [9:0] LP_H     = 10'd40;

    typedef enum logic {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Scored-level synchronizers and rising-edge point strobes
    // ------------------------------------------------------------------
    logic r_p1_meta, r_p1_sync, r_p1_prev;
    logic r_p2_meta, r_p2_sync, r_p2_prev;
    logic w_p1_pt, w_p2_pt;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_p1_meta <= 1'b0;
            r_p1_sync <= 1'b0;
            r_p1_prev <= 1'b0;
            r_p2_meta <= 1'b0;
            r_p2_sync <= 1'b0;
            r_p2_prev <= 1'b0;
        end else begin
            r_p1_meta <= i_p1_scored;
            r_p1_sync <= r_p1_meta;
            r_p1_prev <= r_p1_sync;
            r_p2_meta <= i_p2_scored;
            r_p2_sync <= r_p2_meta;
            r_p2_prev <= r_p2_sync;
        end
    end

    assign w_p1_pt = r_p1_sync & ~r_p1_prev;
    assign w_p2_pt = r_p2_sync & ~r_p2_prev;

    // The UART byte is a one-cycle strobe with no backpressure: a byte counts
    // only in the cycle i_DataValid is high, and is never held or re-sampled.
    logic w_restart;
    assign w_restart = i_DataValid && (i_key_byte == LP_KEY);

    // ------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------
    state_t     r_state, w_state_next;
    logic [3:0] r_p1_score, r_p2_score;
    logic [3:0] w_p1_next, w_p2_next;
    logic       r_winner, w_winner_next;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state    <= ST_PLAY;
            r_p1_score <= 4'd0;
            r_p2_score <= 4'd0;
            r_winner   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_p1_score <= w_p1_next;
            r_p2_score <= w_p2_next;
            r_winner   <= w_winner_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_p1_next     = r_p1_score;
        w_p2_next     = r_p2_score;
        w_winner_next = r_winner;
        if (w_restart) begin
            w_state_next  = ST_PLAY;
            w_p1_next     = 4'd0;
            w_p2_next     = 4'd0;
            w_winner_next = 1'b0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    // Scores are below LP_WIN in PLAY, so one increment cannot overshoot.
                    w_p1_next = r_p1_score + {3'b000, w_p1_pt};
                    w_p2_next = r_p2_score + {3'b000, w_p2_pt};
                    if (w_p1_next == LP_WIN) begin
                        w_state_next  = ST_OVER;
                        w_winner_next = 1'b0;
                    end else if (w_p2_next == LP_WIN) begin
                        w_state_next  = ST_OVER;
                        w_winner_next = 1'b1;
                    end
                end
                ST_OVER: begin
                    w_state_next = ST_OVER;
                end
                default: begin
                    w_state_next = ST_PLAY;
                end
            endcase
        end
    end

    assign o_p1_score  = r_p1_score;
    assign o_p2_score  = r_p2_score;
    assign o_game_over = (r_state == ST_OVER);
    assign o_winner    = r_winner;

    // ------------------------------------------------------------------
    // Seven-segment rendering
    // ------------------------------------------------------------------
    // Segment vector order is {a,b,c,d,e,f,g}.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] segs;
        case (digit)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
        return segs;
    endfunction

    // dx/dy are offsets inside the 24x40 cell; the caller guarantees the bounds.
    function automatic logic seg_lit(input logic [9:0] dx, input logic [9:0] dy,
                                     input logic [6:0] segs);
        logic lit;
        lit = 1'b0;
        if (segs[6] && (dy <= 10'd3))                       lit = 1'b1;
        if (segs[5] && (dx >= 10'd20) && (dy <= 10'd21))    lit = 1'b1;
        if (segs[4] && (dx >= 10'd20) && (dy >= 10'd18))    lit = 1'b1;
        if (segs[3] && (dy >= 10'd36))                      lit = 1'b1;
        if (segs[2] && (dx <= 10'd3) && (dy >= 10'd18))     lit = 1'b1;
        if (segs[1] && (dx <= 10'd3) && (dy <= 10'd21))     lit = 1'b1;
        if (segs[0] && (dy >= 10'd18) && (dy <= 10'd21))    lit = 1'b1;
        return lit;
    endfunction

    logic       w_p1_in, w_p2_in;
    logic [9:0] w_p1_dx, w_p2_dx, w_dy;
    logic       w_p1_blank, w_p2_blank;
    logic       w_pix_on;
    logic       r_pix_on;

    assign w_p1_in = (i_display_x_pos >= LP_P1_X) && (i_display_x_pos < LP_P1_X + LP_W) &&
                     (i_display_y_pos >= LP_Y)    && (i_display_y_pos < LP_Y + LP_H);
    assign w_p2_in = (i_display_x_pos >= LP_P2_X) && (i_display_x_pos < LP_P2_X + LP_W) &&
                     (i_display_y_pos >= LP_Y)    && (i_display_y_pos < LP_Y + LP_H);
    assign w_p1_dx = i_display_x_pos - LP_P1_X;
    assign w_p2_dx = i_display_x_pos - LP_P2_X;
    assign w_dy    = i_display_y_pos - LP_Y;

`ifdef SCORE_BLINK_EN
    // Frame counter ticks on the top-left pixel of each frame.
    logic [4:0] r_frame;
    logic       w_blink_off;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_frame <= 5'd0;
        end else if (w_restart) begin
            r_frame <= 5'd0;
        end else if ((i_display_x_pos == 10'd0) && (i_display_y_pos == 10'd0)) begin
            r_frame <= r_frame + 5'd1;
        end
    end

    assign w_blink_off = (r_state == ST_OVER) && r_frame[4];
    assign w_p1_blank  = w_blink_off && !r_winner;
    assign w_p2_blank  = w_blink_off && r_winner;
`else
    assign w_p1_blank = 1'b0;
    assign w_p2_blank = 1'b0;
`endif

    assign w_pix_on = (w_p1_in && !w_p1_blank && seg_lit(w_p1_dx, w_dy, seg_decode(r_p1_score))) ||
                      (w_p2_in && !w_p2_blank && seg_lit(w_p2_dx, w_dy, seg_decode(r_p2_score)));

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_pix_on <= 1'b0;
        end else begin
            r_pix_on <= w_pix_on;
        end
    end

    assign o_red   = {3{r_pix_on}};
    assign o_green = {3{r_pix_on}};
    assign o_blue  = {3{r_pix_on}};

endmodule

// File: tb/tb_score_board.sv
// Testbench for score_board: cycle-stamped expectations from a behavioural game/display model, checked by a monitor.
// Also exercises the winner-blink behaviour when built with SCORE_BLINK_EN.
`timescale 1ns/1ps
module tb_score_board;

    localparam int P1_X    = 280;
    localparam int P2_X    = 336;
    localparam int DIGIT_Y = 16;
    localparam int WIN     = 5;
    localparam int KEY_R   = 114;
    localparam int IDLE_XY = 1000;

    // Segment rectangles a..g (offsets inside the cell) and digit masks (bit0 = a ... bit6 = g).
    localparam int SX0 [7] = '{0, 20, 20, 0, 0, 0, 0};
    localparam int SX1 [7] = '{23, 23, 23, 23, 3, 3, 23};
    localparam int SY0 [7] = '{0, 0, 18, 36, 18, 0, 18};
    localparam int SY1 [7] = '{3, 21, 39, 39, 39, 21, 21};
    localparam logic [6:0] DIGIT_MASK [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // ---------------- clock / reset ----------------
    logic       i_CLK = 1'b0;
    logic       i_RST = 1'b1;
    logic       i_p1_scored = 1'b0;
    logic       i_p2_scored = 1'b0;
    logic       i_DataValid = 1'b0;
    logic [7:0] i_key_byte = 8'd0;
    logic [9:0] i_display_x_pos = 10'(IDLE_XY);
    logic [9:0] i_display_y_pos = 10'(IDLE_XY);
    logic [2:0] o_red, o_green, o_blue;
    logic [3:0] o_p1_score, o_p2_score;
    logic       o_game_over, o_winner;

    always #5 i_CLK = ~i_CLK;

    int cyc = 0;
    always @(posedge i_CLK) cyc <= cyc + 1;

    score_board dut (
        .i_CLK           (i_CLK),
        .i_RST           (i_RST),
        .i_p1_scored     (i_p1_scored),
        .i_p2_scored     (i_p2_scored),
        .i_DataValid     (i_DataValid),
        .i_key_byte      (i_key_byte),
        .i_display_x_pos (i_display_x_pos),
        .i_display_y_pos (i_display_y_pos),
        .o_red           (o_red),
        .o_green         (o_green),
        .o_blue          (o_blue),
        .o_p1_score      (o_p1_score),
        .o_p2_score      (o_p2_score),
        .o_game_over     (o_game_over),
        .o_winner        (o_winner)
    );

    // ---------------- reference model ----------------
    int         m_p1 = 0;
    int         m_p2 = 0;
    bit         m_over = 1'b0;
    bit         m_win = 1'b0;
    logic [4:0] m_frame = 5'd0;

    function automatic logic [8:0] model_rgb(int x, int y);
        int  ax, d, rx, ry;
        bit  blank;
        bit  lit;
        lit = 1'b0;
        for (int p = 0; p < 2; p++) begin
            ax = (p == 0) ? P1_X : P2_X;
            d  = (p == 0) ? m_p1 : m_p2;
            blank = 1'b0;
`ifdef SCORE_BLINK_EN
            blank = m_over && ((p == 1) == m_win) && m_frame[4];
`endif
            if (!blank && x >= ax && x < ax + 24 && y >= DIGIT_Y && y < DIGIT_Y + 40) begin
                rx = x - ax;
                ry = y - DIGIT_Y;
                for (int s = 0; s < 7; s++) begin
                    if (DIGIT_MASK[d][s] && rx >= SX0[s] && rx <= SX1[s] &&
                        ry >= SY0[s] && ry <= SY1[s])
                        lit = 1'b1;
                end
            end
        end
        return lit ? 9'h1FF : 9'h000;
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int         cyc;
        int         kind;   // 0 rgb, 1 p1, 2 p2, 3 game_over, 4 winner
        logic [8:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void check(string nm, logic [8:0] act, logic [8:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push(int c, int k, logic [8:0] v, string nm);
        exp_t e;
        int   pos;
        e.cyc = c; e.kind = k; e.val = v; e.name = nm;
        pos = exp_q.size();
        while (pos > 0 && exp_q[pos-1].cyc > c) pos--;
        exp_q.insert(pos, e);
    endfunction

    function automatic void expect_state(int c, string nm);
        push(c, 1, 9'(m_p1), {nm, "_p1"});
        push(c, 2, 9'(m_p2), {nm, "_p2"});
        push(c, 3, 9'(m_over), {nm, "_over"});
        push(c, 4, 9'(m_win), {nm, "_winner"});
    endfunction

    exp_t       mon_e;
    logic [8:0] mon_act;
    always @(negedge i_CLK) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            mon_e = exp_q.pop_front();
            case (mon_e.kind)
                0:       mon_act = {o_red, o_green, o_blue};
                1:       mon_act = {5'd0, o_p1_score};
                2:       mon_act = {5'd0, o_p2_score};
                3:       mon_act = {8'd0, o_game_over};
                default: mon_act = {8'd0, o_winner};
            endcase
            if (mon_e.cyc < cyc) $display("FAIL %s: expectation for cycle %0d checked late", mon_e.name, mon_e.cyc);
            check(mon_e.name, mon_act, mon_e.val);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    function automatic void model_restart();
        m_p1 = 0; m_p2 = 0; m_over = 1'b0; m_win = 1'b0; m_frame = 5'd0;
    endfunction

    task automatic pix(int x, int y, string nm);
        tick();
        i_display_x_pos = 10'(x);
        i_display_y_pos = 10'(y);
        push(cyc + 1, 0, model_rgb(x, y), nm);
`ifdef SCORE_BLINK_EN
        if (x == 0 && y == 0) m_frame = m_frame + 5'd1;
`endif
        tick();
        i_display_x_pos = 10'(IDLE_XY);
        i_display_y_pos = 10'(IDLE_XY);
    endtask

    task automatic point(bit a, bit b, int hi, int lo, string nm);
        int n;
        tick();
        i_p1_scored = a;
        i_p2_scored = b;
        n = cyc;
        push(n + 2, 1, 9'(m_p1), {nm, "_pre_p1"});
        push(n + 2, 2, 9'(m_p2), {nm, "_pre_p2"});
        if (!m_over) begin
            if (a) m_p1++;
            if (b) m_p2++;
            if (m_p1 == WIN) begin
                m_over = 1'b1; m_win = 1'b0;
            end else if (m_p2 == WIN) begin
                m_over = 1'b1; m_win = 1'b1;
            end
        end
        expect_state(n + 3, nm);
        repeat (hi - 1) tick();
        if (hi > 4) expect_state(cyc + 1, {nm, "_held"});
        tick();
        i_p1_scored = 1'b0;
        i_p2_scored = 1'b0;
        repeat (lo - 1) tick();
    endtask

    task automatic key(int b, string nm);
        tick();
        i_DataValid = 1'b1;
        i_key_byte  = 8'(b);
        if (b == KEY_R) model_restart();
        expect_state(cyc + 1, nm);
        tick();
        i_DataValid = 1'b0;
        i_key_byte  = 8'($urandom_range(0, 255));
    endtask

    task automatic ghost_key(string nm);
        tick();
        i_DataValid = 1'b0;
        i_key_byte  = 8'(KEY_R);
        expect_state(cyc + 1, nm);
        tick();
        i_key_byte  = 8'd0;
    endtask

    // Restart lands in the same cycle as the point strobe (two cycles after the level rises).
    task automatic restart_with_point(bit a, bit b, string nm);
        int n0;
        tick();
        i_p1_scored = a;
        i_p2_scored = b;
        n0 = cyc;
        tick();
        tick();
        i_DataValid = 1'b1;
        i_key_byte  = 8'(KEY_R);
        model_restart();
        expect_state(n0 + 3, nm);
        tick();
        i_DataValid = 1'b0;
        repeat (3) tick();
        i_p1_scored = 1'b0;
        i_p2_scored = 1'b0;
        repeat (4) tick();
        expect_state(cyc + 1, {nm, "_after"});
        tick();
    endtask

    task automatic async_reset(string nm);
        repeat (4) tick();
        #2;
        i_RST = 1'b1;
        #1;
        check({nm, "_p1"},    9'(o_p1_score), 9'd0);
        check({nm, "_p2"},    9'(o_p2_score), 9'd0);
        check({nm, "_over"},  9'(o_game_over), 9'd0);
        check({nm, "_winner"}, 9'(o_winner), 9'd0);
        check({nm, "_rgb"},   {o_red, o_green, o_blue}, 9'd0);
        model_restart();
        tick();
        tick();
        i_RST = 1'b0;
        expect_state(cyc + 1, {nm, "_released"});
        tick();
    endtask

    task automatic rand_pix(string nm);
        pix($urandom_range(P1_X - 4, P2_X + 28), $urandom_range(DIGIT_Y - 4, DIGIT_Y + 44), nm);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int act, b;
        repeat (3) tick();
        i_RST = 1'b0;
        expect_state(cyc + 1, "reset");
        push(cyc + 1, 0, 9'd0, "reset_rgb");
        pix(P1_X + 10, DIGIT_Y + 1, "zero_seg_a");

        for (int i = 0; i < 3; i++) point(1'b1, 1'b0, 10, 10, "p1_pulse");
        pix(P1_X + 10, DIGIT_Y + 19, "three_seg_g");
        pix(P1_X + 1, DIGIT_Y + 30, "three_seg_e_off");

        point(1'b0, 1'b1, 100, 10, "p2_hold100");
        for (int i = 0; i < 4; i++) point(1'b0, 1'b1, 10, 10, "p2_to_win");
        pix(P2_X + 10, DIGIT_Y + 1, "five_seg_a");
        pix(P2_X + 22, DIGIT_Y + 10, "five_seg_b_off");
        point(1'b1, 1'b0, 10, 10, "over_ignore_p1");

        key(113, "over_wrong_key");
        ghost_key("over_key_no_valid");
        restart_with_point(1'b1, 1'b0, "restart_vs_point");

        for (int i = 0; i < 4; i++) point(1'b1, 1'b1, 8, 6, "tie_build");
        pix(P1_X + 22, DIGIT_Y + 30, "four_seg_c");
        point(1'b1, 1'b1, 8, 6, "tie_final");
        key(KEY_R, "restart_after_tie");

`ifdef SCORE_BLINK_EN
        for (int i = 0; i < 5; i++) point(1'b0, 1'b1, 6, 6, "blink_setup");
        for (int f = 0; f < 40; f++) begin
            pix(0, 0, "blink_frame_tick");
            pix(P2_X + 10, DIGIT_Y + 1, "blink_p2");
            pix(P1_X + 10, DIGIT_Y + 1, "blink_p1");
        end
        key(KEY_R, "blink_restart");
`endif

        point(1'b1, 1'b0, 5, 5, "pre_reset_point");
        point(1'b0, 1'b1, 5, 5, "pre_reset_point");
        async_reset("async_reset");

        for (int i = 0; i < 80; i++) begin
            act = $urandom_range(0, 9);
            case (act)
                0, 1, 2: point(1'b1, 1'b0, $urandom_range(1, 6), $urandom_range(3, 8), "rnd_p1");
                3, 4, 5: point(1'b0, 1'b1, $urandom_range(1, 6), $urandom_range(3, 8), "rnd_p2");
                6:       point(1'b1, 1'b1, $urandom_range(1, 6), $urandom_range(3, 8), "rnd_both");
                7:       for (int k = 0; k < 4; k++) rand_pix("rnd_pix");
                8: begin
                    if (m_over) key(KEY_R, "rnd_restart");
                    else begin
                        b = $urandom_range(0, 255);
                        if (b == KEY_R) b = 0;
                        key(b, "rnd_other_key");
                    end
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) restart_with_point($urandom_range(0, 1) == 1, 1'b1, "rnd_restart_pt");
                    else ghost_key("rnd_ghost");
                end
            endcase
            rand_pix("rnd_pix_after");
        end

        repeat (6) tick();
        check("queue_drained", 9'(exp_q.size()), 9'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_board.md
# score_board

Score keeper and score renderer for the pong display path. Takes the per-point flags from the ball engine, holds both players' scores, runs a play/game-over state machine with keyboard restart, and draws each score as a seven-segment digit. Its 3-bit RGB outputs are OR-merged with the paddle and ball rectangle outputs at the top level.

## Interface
- `WIN_SCORE`, 5: score that ends the game; legal range 1..9.
- `RESTART_KEY`, 114: UART byte that restarts the game (ASCII 'r').
- `P1_X`, 280: left column of the player-1 digit.
- `P2_X`, 336: left column of the player-2 digit.
- `DIGIT_Y`, 16: top row of both digits.

Ports:
- `i_CLK`  in  1  pixel clock; the only clock.
- `i_RST`  in  1  reset, asynchronous, active-high.
- `i_p1_scored`  in  1  level from the slow-clock game engine; a rising edge means a player-1 point.
- `i_p2_scored`  in  1  same, for player 2.
- `i_DataValid`  in  1  one-cycle UART byte strobe.
- `i_key_byte`  in  8  UART byte; valid while `i_DataValid` is high.
- `i_display_x_pos`  in  10  current scan column.
- `i_display_y_pos`  in  10  current scan row.
- `o_red`, `o_green`, `o_blue`  out  3 each  digit pixel colour.
- `o_p1_score`, `o_p2_score`  out  4 each  current scores.
- `o_game_over`  out  1  high while in the OVER state.
- `o_winner`  out  1  0 = player 1, 1 = player 2; valid only while `o_game_over` is high.

## Operation
Scored inputs:
- Each scored input passes through a 2-flop synchronizer.
- A rising-edge detector on the synchronized signal gives a one-cycle point strobe.

State machine:
- Two states, PLAY and OVER. Reset enters PLAY.
- PLAY, on a point strobe: increment that player's score.
- PLAY, both strobes in the same cycle: both scores increment.
- PLAY to OVER: when any score reaches `WIN_SCORE`. `o_winner` records the player who reached it. If both reach it in the same cycle, the winner is player 1.
- OVER: point strobes are ignored and scores hold.
- Restart condition: `i_DataValid` high and `i_key_byte == RESTART_KEY`, in either state.
- Restart effect: both scores clear to 0, state goes to PLAY, `o_winner` clears to 0.
- A restart in the same cycle as a point strobe wins; that point is discarded.
- Any other byte, and any byte without `i_DataValid`, has no effect.
- Scores never exceed `WIN_SCORE`. The 4-bit counters therefore cannot wrap.

Rendering:
- Each digit cell is 24 px wide and 40 px tall, anchored at (`Pn_X`, `DIGIT_Y`). All offsets below are relative to the anchor; bars are 4 px thick.
  - a: rows 0..3, columns 0..23.
  - b: columns 20..23, rows 0..21.
  - c: columns 20..23, rows 18..39.
  - d: rows 36..39, columns 0..23.
  - e: columns 0..3, rows 18..39.
  - f: columns 0..3, rows 0..21.
  - g: rows 18..21, columns 0..23.
- Segments use the standard 0–9 decode.
- A pixel is lit when it falls inside a segment that is on for that player's digit. A lit pixel drives 3'b111 on all three channels; any other pixel drives 3'b000.

## Timing
- Reset values: all outputs 0; both scores 0; state PLAY; synchronizer and edge-detect flops 0.
- Reset asserted mid-game clears everything immediately, without waiting for a clock edge.
- Score latency: `o_pN_score` updates on the 3rd `i_CLK` rising edge after the scored input rises (2 synchronizer flops, then the score register).
- `o_game_over` and `o_winner` update in the same cycle as the final score.
- Restart latency: scores, `o_game_over` and `o_winner` clear on the edge following the qualifying `i_DataValid` cycle.
- Pixel path: registered, latency 1 cycle. The RGB value for position (x, y) appears the cycle after that position is presented.
- A scored level that stays high gives exactly one point. Another point needs a low level of at least 2 `i_CLK` cycles first.

## Configuration
- `SCORE_BLINK_EN` defined:
  - A 5-bit frame counter increments on each cycle where x == 0 and y == 0.
  - While in OVER, the winner's digit is blanked whenever counter bit 4 is 1, giving 16 frames on and 16 off.
  - The counter is reset to 0 by `i_RST` and by a restart.
- `SCORE_BLINK_EN` undefined:
  - No frame counter is built.
  - Both digits are drawn steadily in every state.

## Test plan
- Reset, then scan pixel (P1_X+10, DIGIT_Y+1): scores 0/0, `o_game_over` = 0; segment a of digit "0" is lit, so the RGB one cycle later is 3'b111.
- Pulse `i_p1_scored` 3 times (each pulse 10 cycles high, 10 low): `o_p1_score` = 3, each update 3 cycles after its rising edge. Pixel (P1_X+10, DIGIT_Y+19) is lit (segment g) and pixel (P1_X+1, DIGIT_Y+30) is dark (segment e off for "3").
- Hold `i_p2_scored` high for 100 cycles: `o_p2_score` increments exactly once.
- Drive `i_p2_scored` to 5 points: `o_game_over` = 1 and `o_winner` = 1. A further `i_p1_scored` pulse leaves `o_p1_score` unchanged.
- In OVER, present byte 113 with `i_DataValid`: no change. Then present byte 114 in the same cycle as a point strobe: next cycle both scores are 0, `o_game_over` = 0, and the point is discarded.
- With `SCORE_BLINK_EN`, in OVER with winner P2: the P2 digit pixels are dark for frames 16..31 of the counter and lit for frames 0..15; the P1 digit stays lit throughout.
